// File: rtl/rv_fetch_pkg.sv
// Shared types and defaults for the fetch queue slice.
package rv_fetch_pkg;

  localparam int unsigned FQ_DEPTH_DEFAULT = 4;
  localparam int unsigned FQ_PTR_W_DEFAULT = $clog2(FQ_DEPTH_DEFAULT);

  // Wrap-bit pointer at the default depth; the top re-derives its own width from DEPTH.
  typedef logic [FQ_PTR_W_DEFAULT:0] fq_ptr_t;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] instr;
    logic        filled;
  } fq_entry_t;

endpackage

// File: rtl/rv_fetch_queue_ram.sv
// Fetch queue storage: alloc writes pc, fill writes instr and sets filled, async head read.
module rv_fetch_queue_ram
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_we_i,
  input  logic [IDX_W-1:0] alloc_idx_i,
  input  logic [31:2]      alloc_pc_i,
  input  logic             fill_we_i,
  input  logic [IDX_W-1:0] fill_idx_i,
  input  logic [31:0]      fill_instr_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output fq_entry_t        rd_entry_o
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i].filled <= 1'b0;
      end
    end else begin
      if (alloc_we_i) begin
        mem_q[alloc_idx_i].pc     <= alloc_pc_i;
        mem_q[alloc_idx_i].filled <= 1'b0;
      end
      if (fill_we_i) begin
        mem_q[fill_idx_i].instr  <= fill_instr_i;
        mem_q[fill_idx_i].filled <= 1'b1;
      end
    end
  end

  assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/rv_fetch_queue.sv
// In-order instruction fetch queue with credit-based issue and flush drop counting.
// Define RV_FETCH_QUEUE_BYPASS_EN for a zero-latency response-to-decode path.
module rv_fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [29:0] i_pc,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic [29:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [29:0] o_pc,
  input  logic        i_ready
);

  logic [PTR_W:0]   alloc_q, alloc_d, fill_q, fill_d, ret_q, ret_d, drop_q, drop_d;
  logic [PTR_W:0]   used, pending;
  logic [PTR_W+1:0] credit_sum;
  logic             can_issue, accept, rsp_drop, rsp_fill, head_ok, bypass, pop, fill_we;
  fq_entry_t        head;

  assign used       = alloc_q - ret_q;
  assign pending    = alloc_q - fill_q;
  assign credit_sum = {1'b0, used} + {1'b0, drop_q};

  assign can_issue  = !i_reset && !i_flush && (credit_sum < (PTR_W+2)'(DEPTH));
  assign o_bus_req  = can_issue;
  assign o_bus_addr = i_pc;
  assign accept     = can_issue && i_bus_ack;
  assign o_stall    = !accept;

  assign rsp_drop = i_bus_rvalid && (drop_q != '0);
  assign rsp_fill = i_bus_rvalid && (drop_q == '0) && (pending != '0);
  assign head_ok  = (used != '0) && head.filled;

`ifdef RV_FETCH_QUEUE_BYPASS_EN
  // With a single unfilled entry, the arriving response is necessarily the head's.
  assign bypass = (used == (PTR_W+1)'(1)) && !head.filled && rsp_fill;
`else
  assign bypass = 1'b0;
`endif

  assign o_valid = !i_reset && !i_flush && (head_ok || bypass);
  assign o_instr = bypass ? i_bus_rdata : head.instr;
  assign o_pc    = head.pc;
  assign pop     = o_valid && i_ready;
  assign fill_we = rsp_fill && !i_flush && !(bypass && i_ready);

  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    ret_d   = ret_q;
    drop_d  = drop_q;
    if (i_flush) begin
      alloc_d = '0;
      fill_d  = '0;
      ret_d   = '0;
      // Every reply still owed becomes stale, less the one consumed this cycle.
      drop_d  = drop_q + pending - {{PTR_W{1'b0}}, (rsp_drop || rsp_fill)};
    end else begin
      if (accept)   alloc_d = alloc_q + 1'b1;
      if (rsp_fill) fill_d  = fill_q + 1'b1;
      if (pop)      ret_d   = ret_q + 1'b1;
      if (rsp_drop) drop_d  = drop_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alloc_q <= '0;
      fill_q  <= '0;
      ret_q   <= '0;
      drop_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      ret_q   <= ret_d;
      drop_q  <= drop_d;
    end
  end

  rv_fetch_queue_ram #(
    .DEPTH (DEPTH),
    .IDX_W (PTR_W)
  ) u_ram (
    .clk_i        (i_clk),
    .rst_i        (i_reset),
    .alloc_we_i   (accept),
    .alloc_idx_i  (alloc_q[PTR_W-1:0]),
    .alloc_pc_i   (i_pc),
    .fill_we_i    (fill_we),
    .fill_idx_i   (fill_q[PTR_W-1:0]),
    .fill_instr_i (i_bus_rdata),
    .rd_idx_i     (ret_q[PTR_W-1:0]),
    .rd_entry_o   (head)
  );

  a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (i_reset)
    i_bus_rvalid |-> ((pending != '0) || (drop_q != '0)));

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Scoreboard bench for rv_fetch_queue: queue-level reference model plus decoupled output monitor.
module tb_rv_fetch_queue;

  localparam int DEPTH = 4;
`ifdef RV_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_reset = 1'b1, i_flush = 1'b0, i_bus_ack = 1'b0, i_bus_rvalid = 1'b0, i_ready = 1'b0;
  logic [29:0] i_pc = '0;
  logic [31:0] i_bus_rdata = '0;
  logic        o_stall, o_bus_req, o_valid;
  logic [29:0] o_bus_addr, o_pc;
  logic [31:0] o_instr;

  always #5 clk = ~clk;

  rv_fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_pc(i_pc), .i_flush(i_flush),
    .o_stall(o_stall), .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr),
    .i_bus_ack(i_bus_ack), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready)
  );

  typedef struct { logic [29:0] pc; logic [31:0] instr; bit filled; } exp_t;
  typedef struct { logic [31:0] data; bit live; } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  int          checks = 0, failures = 0, pops = 0;
  logic [29:0] cur_pc = 30'h10;
  logic [29:0] flush_pc = 30'h40;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int stale_cnt();
    int n = 0;
    foreach (bus_q[i]) if (!bus_q[i].live) n++;
    return n;
  endfunction

  function automatic bit credit_ok();
    return (exp_q.size() + stale_cnt()) < DEPTH;
  endfunction

  // Monitor: compares control outputs and pops the scoreboard on each decode handshake.
  always @(negedge clk) begin : mon
    bit er, ev;
    er = !i_reset && !i_flush && credit_ok();
    chk("bus_req", o_bus_req, er);
    chk("stall", o_stall, !(er && i_bus_ack));
    if (er) chk("bus_addr", o_bus_addr, i_pc);
    if (i_reset) begin
      chk("valid_in_reset", o_valid, 1'b0);
    end else if (!i_flush) begin
      ev = (exp_q.size() > 0) && exp_q[0].filled;
      if (BYP && exp_q.size() == 1 && !exp_q[0].filled && i_bus_rvalid &&
          bus_q.size() > 0 && bus_q[0].live)
        ev = 1'b1;
      chk("valid", o_valid, ev);
      if (ev && i_ready) begin
        chk("out_pc", o_pc, exp_q[0].pc);
        chk("out_instr", o_instr, exp_q[0].instr);
        void'(exp_q.pop_front());
        pops++;
      end
    end
  end

  // One clock of stimulus, followed by the reference-model update for that edge.
  task automatic step(input bit rst, input bit fl, input bit ack, input bit rv, input bit rdy);
    bit   acc;
    bus_t b;
    exp_t e;
    @(posedge clk); #1;
    i_reset   = rst;
    i_flush   = fl;
    i_bus_ack = ack;
    i_ready   = rdy;
    i_pc      = cur_pc;
    if (rv && bus_q.size() > 0) begin
      i_bus_rvalid = 1'b1;
      i_bus_rdata  = bus_q[0].data;
    end else begin
      i_bus_rvalid = 1'b0;
      i_bus_rdata  = $urandom;
    end
    acc = ack && !fl && !rst && credit_ok();
    @(negedge clk); #1;
    if (rst) begin
      exp_q.delete();
      bus_q.delete();
    end else begin
      if (i_bus_rvalid) begin
        b = bus_q.pop_front();
        if (b.live) begin
          for (int i = 0; i < exp_q.size(); i++)
            if (!exp_q[i].filled) begin exp_q[i].filled = 1'b1; break; end
        end
      end
      if (fl) begin
        exp_q.delete();
        foreach (bus_q[i]) begin bus_q[i].live = 1'b0; bus_q[i].data = 32'hDEAD_BEEF; end
        cur_pc = flush_pc;
      end else if (acc) begin
        b.data = $urandom; b.live = 1'b1;
        bus_q.push_back(b);
        e.pc = cur_pc; e.instr = b.data; e.filled = 1'b0;
        exp_q.push_back(e);
        cur_pc = cur_pc + 1'b1;
      end
    end
  endtask

  initial begin
    int p0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Streaming from 0x40
    cur_pc = 30'h10;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 1, 1);
      chk("stream_stall", o_stall, 1'b0);
    end
    chk("stream_pops", pops - p0, 18);

    // Reset mid-operation with filled entries queued
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 1, 1, 1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_req", o_bus_req, 1'b0);
    chk("rst_stall", o_stall, 1'b1);
    step(0, 0, 1, 0, 0);
    chk("post_rst_req", o_bus_req, 1'b1);

    // Full
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 0);
      chk("fill_req", o_bus_req, 1'b1);
    end
    step(0, 0, 1, 1, 0);
    chk("full_req", o_bus_req, 1'b0);
    chk("full_stall", o_stall, 1'b1);
    step(0, 0, 1, 1, 1);
    chk("full_pop_valid", o_valid, 1'b1);
    chk("full_pop_req", o_bus_req, 1'b0);
    step(0, 0, 1, 1, 0);
    chk("after_pop_req", o_bus_req, 1'b1);

    // Flush with three reads in flight
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    flush_pc = 30'h40;
    step(0, 1, 1, 0, 0);
    chk("flush_req", o_bus_req, 1'b0);
    chk("flush_stall", o_stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1);
      chk("drain_valid", o_valid, 1'b0);
    end
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("redirect_valid", o_valid, 1'b1);
    chk("redirect_pc", o_pc, 30'h40);

    // Flush coinciding with a response and a pop
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_flush_valid", o_valid, 1'b1);
    flush_pc = 30'h80;
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("post_flush_valid", o_valid, 1'b0);
    step(0, 0, 0, 1, 1);
    chk("stale_drop_valid", o_valid, 1'b0);

    // Response-to-decode latency
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    bus_q[0].data = 32'h0000_0013;
    exp_q[0].instr = 32'h0000_0013;
    step(0, 0, 0, 1, 1);
    chk("bypass_valid", o_valid, BYP);
    if (BYP) chk("bypass_instr", o_instr, 32'h0000_0013);
    step(0, 0, 0, 0, 1);
    chk("late_valid", o_valid, !BYP);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 800; i++) begin
      flush_pc = 30'($urandom);
      step(($urandom_range(99) == 0), ($urandom_range(19) == 0), ($urandom_range(9) < 7),
           ($urandom_range(9) < 6), ($urandom_range(9) < 7));
    end
    step(1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
